// File: rtl/non_restor_seq.sv
// Sequential non-restoring integer square root, one root bit per clock; SQRT_ROUND_EN selects round-to-nearest root.
// Latency: result valid DATA_WIDTH/2 clocks after accept; one result per DATA_WIDTH/2+1 clocks at full rate.
// Backpressure: result held in DONE until out_ready; a new operand is accepted on the same handshake edge.
module non_restor_seq #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] din,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH/2:0] root,
  output logic [DATA_WIDTH/2:0] rem
);

  localparam int N   = DATA_WIDTH / 2;
  localparam int RW  = N + 1;
  localparam int RW1 = RW + 1;
  localparam int CW  = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] d_q;
  logic [RW:0]           r_q;      // two's complement partial remainder, sign at [RW]
  logic [N-1:0]          q_q;
  logic [CW-1:0]         cnt_q;

  logic                  accept;
  logic                  last;
  logic [1:0]            pair;
  logic [RW:0]           r_nxt;
  logic [RW-1:0]         q_nxt;
  logic [RW-1:0]         rem_nxt;
  logic [RW-1:0]         root_nxt;

  assign in_ready = (state_q == IDLE) | ((state_q == DONE) & out_ready);
  assign accept   = in_valid & in_ready;
  assign last     = (state_q == CALC) && (cnt_q == '0);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid) state_d = CALC;
      CALC:    if (cnt_q == '0) state_d = DONE;
      DONE:    if (out_ready) state_d = in_valid ? CALC : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // The remainder provably fits RW+1 bits, so the wide intermediate is truncated mod 2^(RW+1).
  always_comb begin
    pair = 2'(d_q >> {cnt_q, 1'b0});
    if (r_q[RW]) r_nxt = RW1'({r_q, pair} + {2'b00, q_q, 2'b11});
    else         r_nxt = RW1'({r_q, pair} - {2'b00, q_q, 2'b01});
    q_nxt   = {q_q, ~r_nxt[RW]};
    rem_nxt = r_nxt[RW] ? RW'(r_nxt + {q_nxt, 1'b1}) : r_nxt[RW-1:0];
`ifdef SQRT_ROUND_EN
    root_nxt = (rem_nxt > q_nxt) ? q_nxt + RW'(1) : q_nxt;
`else
    root_nxt = q_nxt;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      d_q       <= '0;
      r_q       <= '0;
      q_q       <= '0;
      cnt_q     <= '0;
      root      <= '0;
      rem       <= '0;
      out_valid <= 1'b0;
    end else begin
      if (accept) begin
        d_q   <= din;
        r_q   <= '0;
        q_q   <= '0;
        cnt_q <= CW'(N - 1);
      end else if (state_q == CALC) begin
        r_q <= r_nxt;
        q_q <= q_nxt[N-1:0];
        if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
      end

      // The old result retires on its handshake; a fresh operand needs N clocks anyway.
      if (last) begin
        root      <= root_nxt;
        rem       <= rem_nxt;
        out_valid <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_non_restor_seq.sv
// Directed bench for non_restor_seq at DATA_WIDTH 8 and 16; expectations follow SQRT_ROUND_EN.
module tb_non_restor_seq;

`ifdef SQRT_ROUND_EN
  localparam int R140 = 12, R255 = 16, R65535 = 256;
`else
  localparam int R140 = 11, R255 = 15, R65535 = 255;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        iv8, ir8, ov8, or8;
  logic [7:0]  d8;
  logic [4:0]  root8, rem8;
  logic        iv16, ir16, ov16, or16;
  logic [15:0] d16;
  logic [8:0]  root16, rem16;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  non_restor_seq #(.DATA_WIDTH(8)) dut8 (
    .clk(clk), .rst(rst),
    .in_valid(iv8), .in_ready(ir8), .din(d8),
    .out_valid(ov8), .out_ready(or8), .root(root8), .rem(rem8)
  );

  non_restor_seq #(.DATA_WIDTH(16)) dut16 (
    .clk(clk), .rst(rst),
    .in_valid(iv16), .in_ready(ir16), .din(d16),
    .out_valid(ov16), .out_ready(or16), .root(root16), .rem(rem16)
  );

  task automatic wait_valid(input bit wide, output int n);
    n = 0;
    while (((wide ? ov16 : ov8) !== 1'b1) && n < 64) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; iv8 = 1'b0; or8 = 1'b0; d8 = '0;
    iv16 = 1'b0; or16 = 1'b0; d16 = '0;
    repeat (3) @(posedge clk);
    #1;
    n_chk++; if (ov8 !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %0b want 0", ov8); end
    n_chk++; if (root8 !== 5'd0) begin n_fail++; $display("FAIL reset_root got %0d want 0", root8); end
    n_chk++; if (rem8 !== 5'd0) begin n_fail++; $display("FAIL reset_rem got %0d want 0", rem8); end
    n_chk++; if (ir8 !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %0b want 1", ir8); end
    n_chk++; if (ov16 !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid16 got %0b want 0", ov16); end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic;
    int n;
    or8 = 1'b1; d8 = 8'd140; iv8 = 1'b1;
    n_chk++; if (ir8 !== 1'b1) begin n_fail++; $display("FAIL basic_in_ready got %0b want 1", ir8); end
    @(posedge clk); #1;
    iv8 = 1'b0; d8 = 8'd3;
    wait_valid(1'b0, n);
    n_chk++; if (n !== 4) begin n_fail++; $display("FAIL basic_latency got %0d want 4", n); end
    n_chk++; if (root8 !== R140) begin n_fail++; $display("FAIL basic_root got %0d want %0d", root8, R140); end
    n_chk++; if (rem8 !== 5'd19) begin n_fail++; $display("FAIL basic_rem got %0d want 19", rem8); end
    @(posedge clk); #1;
    n_chk++; if (ov8 !== 1'b0) begin n_fail++; $display("FAIL basic_drop got %0b want 0", ov8); end
  endtask

  task automatic test_edges;
    logic [7:0] vin [2]  = '{8'd0, 8'd255};
    int         er  [2]  = '{0, R255};
    int         em  [2]  = '{0, 30};
    int n;
    or8 = 1'b1;
    for (int i = 0; i < 2; i++) begin
      d8 = vin[i]; iv8 = 1'b1;
      @(posedge clk); #1;
      iv8 = 1'b0;
      wait_valid(1'b0, n);
      n_chk++; if (n !== 4) begin n_fail++; $display("FAIL edge_latency[%0d] got %0d want 4", i, n); end
      n_chk++; if (root8 !== er[i]) begin n_fail++; $display("FAIL edge_root[%0d] got %0d want %0d", i, root8, er[i]); end
      n_chk++; if (rem8 !== em[i]) begin n_fail++; $display("FAIL edge_rem[%0d] got %0d want %0d", i, rem8, em[i]); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_backpressure;
    int n;
    or8 = 1'b0; d8 = 8'd144; iv8 = 1'b1;
    @(posedge clk); #1;
    iv8 = 1'b0;
    wait_valid(1'b0, n);
    n_chk++; if (n !== 4) begin n_fail++; $display("FAIL bp_latency got %0d want 4", n); end
    iv8 = 1'b1; d8 = 8'd3;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      n_chk++;
      if (ov8 !== 1'b1 || root8 !== 5'd12 || rem8 !== 5'd0 || ir8 !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_hold[%0d] got v=%0b root=%0d rem=%0d rdy=%0b want v=1 root=12 rem=0 rdy=0",
                 c, ov8, root8, rem8, ir8);
      end
    end
    iv8 = 1'b0; or8 = 1'b1;
    #1;
    n_chk++; if (ir8 !== 1'b1) begin n_fail++; $display("FAIL bp_ready_comb got %0b want 1", ir8); end
    @(posedge clk); #1;
    n_chk++; if (ov8 !== 1'b0) begin n_fail++; $display("FAIL bp_drop got %0b want 0", ov8); end
    or8 = 1'b0;
    #1;
    n_chk++; if (ir8 !== 1'b1) begin n_fail++; $display("FAIL bp_idle_ready got %0b want 1", ir8); end
  endtask

  task automatic test_back_to_back;
    int n;
    or8 = 1'b1; d8 = 8'd49; iv8 = 1'b1;
    @(posedge clk); #1;
    d8 = 8'd50;
    wait_valid(1'b0, n);
    n_chk++; if (n !== 4) begin n_fail++; $display("FAIL b2b_latency1 got %0d want 4", n); end
    n_chk++; if (root8 !== 5'd7 || rem8 !== 5'd0) begin n_fail++; $display("FAIL b2b_res1 got %0d/%0d want 7/0", root8, rem8); end
    n_chk++; if (ir8 !== 1'b1) begin n_fail++; $display("FAIL b2b_ready got %0b want 1", ir8); end
    @(posedge clk); #1;
    iv8 = 1'b0;
    n_chk++; if (ov8 !== 1'b0 || ir8 !== 1'b0) begin n_fail++; $display("FAIL b2b_busy got v=%0b rdy=%0b want 0/0", ov8, ir8); end
    wait_valid(1'b0, n);
    n_chk++; if (n + 1 !== 5) begin n_fail++; $display("FAIL b2b_spacing got %0d want 5", n + 1); end
    n_chk++; if (root8 !== 5'd7 || rem8 !== 5'd1) begin n_fail++; $display("FAIL b2b_res2 got %0d/%0d want 7/1", root8, rem8); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_abort;
    int n;
    bit seen;
    or8 = 1'b1; d8 = 8'd200; iv8 = 1'b1;
    @(posedge clk); #1;
    iv8 = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    n_chk++;
    if (ov8 !== 1'b0 || root8 !== 5'd0 || rem8 !== 5'd0 || ir8 !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_state got v=%0b root=%0d rem=%0d rdy=%0b want 0/0/0/1", ov8, root8, rem8, ir8);
    end
    rst = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      if (ov8 !== 1'b0) seen = 1'b1;
    end
    n_chk++; if (seen) begin n_fail++; $display("FAIL abort_no_result got 1 want 0"); end
    d8 = 8'd81; iv8 = 1'b1;
    @(posedge clk); #1;
    iv8 = 1'b0;
    wait_valid(1'b0, n);
    n_chk++; if (n !== 4) begin n_fail++; $display("FAIL abort_latency got %0d want 4", n); end
    n_chk++; if (root8 !== 5'd9 || rem8 !== 5'd0) begin n_fail++; $display("FAIL abort_res got %0d/%0d want 9/0", root8, rem8); end
    @(posedge clk); #1;
  endtask

  task automatic test_width16;
    logic [15:0] vin [2] = '{16'd65535, 16'd40000};
    int          er  [2] = '{R65535, 200};
    int          em  [2] = '{510, 0};
    int n;
    or16 = 1'b1;
    for (int i = 0; i < 2; i++) begin
      d16 = vin[i]; iv16 = 1'b1;
      @(posedge clk); #1;
      iv16 = 1'b0;
      wait_valid(1'b1, n);
      n_chk++; if (n !== 8) begin n_fail++; $display("FAIL w16_latency[%0d] got %0d want 8", i, n); end
      n_chk++; if (root16 !== er[i]) begin n_fail++; $display("FAIL w16_root[%0d] got %0d want %0d", i, root16, er[i]); end
      n_chk++; if (rem16 !== em[i]) begin n_fail++; $display("FAIL w16_rem[%0d] got %0d want %0d", i, rem16, em[i]); end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_edges();
    test_backpressure();
    test_back_to_back();
    test_reset_abort();
    test_width16();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
